// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, iterated
// LSB first over WIDTH clocks. Subtraction is a + ~b + 1 with the +1 as carry-in.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // One-hot so that busy and done decode straight from a single state flop.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic            carry;
    logic            carry_nx;
    logic            s_bit;
    logic [CW-1:0]   cnt;
    logic            last;

    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last     = (cnt == CW'(WIDTH - 1));

    always_comb begin
        res_nx            = res_sh >> 1;
        res_nx[WIDTH-1]   = s_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_sh   <= a;
                b_sh   <= sub ? ~b : b;
                carry  <= sub;
                cnt    <= '0;
                res_sh <= '0;
            end
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= carry_nx;
            res_sh <= res_nx;
            cnt    <= cnt + CW'(1);
            // Outputs move only when the last bit lands, then hold through IDLE.
            if (last) begin
                sum  <= res_nx;
                cout <= carry_nx;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit and a 1-bit instance driven in turn, with a
// queue-based scoreboard checked by a monitor on every done pulse.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1 = 1'b0, sub1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [32:0] exp_q8[$];
    logic [32:0] exp_q1[$];
    int          lat_q8[$];
    int          lat_q1[$];
    logic [32:0] held8 = '0;
    logic [32:0] held1 = '0;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic; cout is the add carry or "no borrow".
    function automatic logic [32:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        longint unsigned m, aa, bb, r;
        logic c;
        m  = (64'd1 << w) - 1;
        aa = 64'(a) & m;
        bb = 64'(b) & m;
        if (!s) begin
            r = aa + bb;
            c = ((r >> w) & 64'd1) != 0;
        end else begin
            r = aa - bb;
            c = (aa >= bb);
        end
        return {c, 32'(r & m)};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy8 && done8) check("busy8_and_done8", 1, 0);
            if (busy1 && done1) check("busy1_and_done1", 1, 0);
            if (done8) begin
                if (exp_q8.size() == 0) check("unexpected_done8", 1, 0);
                else begin
                    held8 = exp_q8.pop_front();
                    check("sum8", 64'(sum8), 64'(held8[7:0]));
                    check("cout8", 64'(cout8), 64'(held8[32]));
                    check("latency8", 64'(cyc), 64'(lat_q8.pop_front()));
                end
            end else begin
                check("hold8", {cout8, sum8}, {held8[32], held8[7:0]});
            end
            if (done1) begin
                if (exp_q1.size() == 0) check("unexpected_done1", 1, 0);
                else begin
                    held1 = exp_q1.pop_front();
                    check("sum1", 64'(sum1), 64'(held1[0]));
                    check("cout1", 64'(cout1), 64'(held1[32]));
                    check("latency1", 64'(cyc), 64'(lat_q1.pop_front()));
                end
            end else begin
                check("hold1", {cout1, sum1}, {held1[32], held1[0]});
            end
        end
    end

    task automatic wait_idle(input int which);
        int n = 0;
        while (((which == 8) ? (busy8 | done8) : (busy1 | done1)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n < 200), 1);
    endtask

    task automatic op(input int which, input logic [31:0] a, input logic [31:0] b, input logic s);
        wait_idle(which);
        if (which == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; sub8 = s; start8 = 1'b1;
            exp_q8.push_back(ref_op(8, a, b, s));
            lat_q8.push_back(cyc + 1 + 8);
            @(negedge clk);
            start8 = 1'b0;
            check("busy8_after_start", 64'(busy8), 1);
        end else begin
            a1 = a[0:0]; b1 = b[0:0]; sub1 = s; start1 = 1'b1;
            exp_q1.push_back(ref_op(1, a, b, s));
            lat_q1.push_back(cyc + 1 + 1);
            @(negedge clk);
            start1 = 1'b0;
            check("busy1_after_start", 64'(busy1), 1);
        end
    endtask

    initial begin
        int e;
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy8", 64'(busy8), 0);
        check("rst_done8", 64'(done8), 0);
        check("rst_sum8", {cout8, sum8}, 0);
        check("rst_sum1", {busy1, done1, cout1, sum1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed add / carry wrap / subtract cases.
        op(8, 32'h3C, 32'h05, 1'b0);
        op(8, 32'hFF, 32'h01, 1'b0);
        op(8, 32'hFF, 32'hFF, 1'b0);
        op(8, 32'h05, 32'h03, 1'b1);
        op(8, 32'h03, 32'h05, 1'b1);

        // Starts during RUN and DONE are ignored; a held start re-enters at edge 10.
        wait_idle(8);
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        exp_q8.push_back(ref_op(8, 32'h10, 32'h20, 1'b0));
        e = cyc + 1;
        lat_q8.push_back(e + 8);
        @(negedge clk); start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hAA; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        while (cyc < e + 8) @(negedge clk);
        check("done_at_edge8", 64'(done8), 1);
        a8 = 8'hAA; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        exp_q8.push_back(ref_op(8, 32'hAA, 32'h01, 1'b0));
        lat_q8.push_back(e + 10 + 8);
        @(negedge clk);
        check("idle_at_edge9", 64'({busy8, done8}), 0);
        @(negedge clk);
        check("reaccept_at_edge10", 64'(busy8), 1);
        start8 = 1'b0;

        // Reset four cycles into RUN aborts without a done pulse.
        wait_idle(8);
        a8 = 8'h77; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
        e = cyc + 1;
        @(negedge clk); start8 = 1'b0;
        while (cyc < e + 4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy8), 0);
        check("abort_done", 64'(done8), 0);
        check("abort_sum", {cout8, sum8}, 0);
        held8 = '0;
        held1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(8, 32'h01, 32'h01, 1'b0);

        // WIDTH=1: full-adder truth table with cin=sub, y=b^sub.
        for (int s = 0; s < 2; s++)
            for (int ab = 0; ab < 4; ab++)
                op(1, 32'(ab >> 1), 32'(ab & 1), s[0]);

        for (int i = 0; i < 30; i++) begin
            op(8, $urandom, $urandom, 1'($urandom_range(0, 1)));
            op(1, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        n = 0;
        while ((exp_q8.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pending_expectations", 64'(exp_q8.size() + exp_q1.size()), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It accepts two WIDTH-bit operands on a start pulse and processes them LSB first, one bit per clock. It returns the WIDTH-bit result plus carry-out with a one-cycle done pulse. It is the sequential counterpart of the combinational full adder: the same x/y/Cin → Sum/Cout cell, iterated over time, with a subtract direction added.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add (a+b), 1 = subtract (a−b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  final carry; for subtract, 1 = no borrow (a ≥ b unsigned).

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1 → RUN. On that edge:
  - Load a_sh←a, b_sh←(sub ? ~b : b), carry←sub, bit counter←0.
  - Clear the sum shift register.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - carry ← majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by one.
  - Shift s into the result MSB (result shifts right).
  - Increment the counter.
- RUN → DONE on the edge that processes bit WIDTH−1 (counter == WIDTH−1).
- DONE → IDLE unconditionally on the next edge.
- sum and cout are updated only on the RUN→DONE edge and hold through IDLE.
- start is ignored in RUN and DONE; it is not queued.
- sub, a and b are don't-care outside the accepting IDLE edge.
- Arithmetic is modulo 2^WIDTH; overflow is reported only through cout. There is no signed-overflow flag.

## Timing
- Reset (asynchronous, any time): state=IDLE, busy=0, done=0, sum=0, cout=0, internal registers=0.
- Reset mid-RUN aborts the operation; no done is produced. The first start after rst_n deasserts is accepted normally.
- Start accepted at edge 0 → busy=1 from after edge 0 through edge WIDTH.
- busy=0 and done=1 for exactly one cycle after edge WIDTH.
- done=0 after edge WIDTH+1.
- Latency from start edge to done high: WIDTH cycles.
- Minimum spacing between accepted starts: WIDTH+2 cycles. A start held high continuously is accepted again at edge WIDTH+2.
- WIDTH=1: RUN lasts one cycle; done follows at edge 1.
- busy and done are registered outputs; neither is ever high in the same cycle as the other.

## Test plan
- Add, WIDTH=8: a=8'h3C, b=8'h05, sub=0 → after 8 cycles done pulses once, sum=8'h41, cout=0.
- Carry wrap: a=8'hFF, b=8'h01, sub=0 → sum=8'h00, cout=1. Also check a=8'hFF, b=8'hFF → sum=8'hFE, cout=1.
- Subtract: a=8'h05, b=8'h03, sub=1 → sum=8'h02, cout=1. Then a=8'h03, b=8'h05 → sum=8'hFE, cout=0 (borrow).
- WIDTH=1 sweep of all four (a,b) pairs with sub=0 and sub=1:
  - Check against the full-adder truth table with Cin=sub and y=b^sub.
  - Example: a=1, b=1, sub=0 → sum=0, cout=1.
  - Example: a=0, b=1, sub=1 → sum=1, cout=0.
- Start while busy: accept a=8'h10, b=8'h20. Pulse start with a=8'hAA at cycles 3 and 8 (DONE) → ignored, single done, sum=8'h30. Held-high start is re-accepted at edge 10.
- Reset mid-operation: assert rst_n=0 at cycle 4 of RUN:
  - Immediately busy=0, sum=0, cout=0, done never pulses.
  - After release, a=8'h01, b=8'h01, sub=0 → sum=8'h02.
